// File: rtl/collision_monitor.sv
// Collision monitor: registered car/obstacle overlap, hit filtering, BCD score and game FSM.
// Optional lives counter and lives[2:0] output when LIVES_EN is defined.
module collision_monitor #(
  parameter int CAR_W      = 40,
  parameter int CAR_H      = 60,
  parameter int OBS_W      = 50,
  parameter int OBS_H      = 50,
  parameter int HIT_FRAMES = 2,
  parameter int LIVES_INIT = 3
) (
  input  logic        iVGA_CLK,
  input  logic        reset_game,
  input  logic        frame_tick,
  input  logic        btn_start,
  input  logic [9:0]  car_h_pos,
  input  logic [8:0]  car_v_pos,
  input  logic [9:0]  obs1_h_pos,
  input  logic [8:0]  obs1_v_pos,
  input  logic [9:0]  obs2_h_pos,
  input  logic [8:0]  obs2_v_pos,
  output logic        game_over,
  output logic        hit_flash,
  output logic        restart_req,
`ifdef LIVES_EN
  output logic [2:0]  lives,
`endif
  output logic [15:0] score_bcd
);

  typedef enum logic [1:0] {IDLE, PLAYING, GAME_OVER} state_t;

  localparam logic [10:0] CAR_W11 = 11'(CAR_W);
  localparam logic [10:0] CAR_H11 = 11'(CAR_H);
  localparam logic [10:0] OBS_W11 = 11'(OBS_W);
  localparam logic [10:0] OBS_H11 = 11'(OBS_H);
  localparam logic [3:0]  HIT_N   = 4'(HIT_FRAMES);

  state_t      state_q;
  logic        game_over_q, hit_flash_q, restart_req_q, btn_q;
  logic [15:0] score_q, score_d, score_one, score_two;
  logic [3:0]  cnt_q [2];
  logic [3:0]  cnt_d [2];
  logic [8:0]  prev_v_q [2];
  logic [9:0]  obs_h [2];
  logic [8:0]  obs_v [2];
  logic [1:0]  hit_obs, wrap;
  logic        hit, btn_rise;
`ifdef LIVES_EN
  localparam logic [2:0] LIVES_N = 3'(LIVES_INIT);
  logic [2:0]  lives_q;
  assign lives = lives_q;
`endif

  assign obs_h[0] = obs1_h_pos;
  assign obs_h[1] = obs2_h_pos;
  assign obs_v[0] = obs1_v_pos;
  assign obs_v[1] = obs2_v_pos;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_obs
      logic        ov_q;
      logic [10:0] oh, ov, ch, cv;
      assign oh = {1'b0, obs_h[gi]};
      assign ov = {2'b0, obs_v[gi]};
      assign ch = {1'b0, car_h_pos};
      assign cv = {2'b0, car_v_pos};
      always_ff @(posedge iVGA_CLK) begin
        if (reset_game) ov_q <= 1'b0;
        else ov_q <= (ch < oh + OBS_W11) && (oh < ch + CAR_W11) &&
                     (cv < ov + OBS_H11) && (ov < cv + CAR_H11);
      end
      assign cnt_d[gi]   = !ov_q ? 4'd0 : (cnt_q[gi] == 4'hF) ? 4'hF : cnt_q[gi] + 4'd1;
      assign hit_obs[gi] = (cnt_d[gi] == HIT_N);
      // A wrap is an obstacle jumping back toward the top of the screen
      assign wrap[gi]    = obs_v[gi] < prev_v_q[gi];
    end
  endgenerate

  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r     = s;
    carry = 1'b1;
    if (s == 16'h9999) return s;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign score_one = bcd_inc(score_q);
  assign score_two = bcd_inc(score_one);
  assign hit       = |hit_obs;
  assign btn_rise  = btn_start & ~btn_q;

  always_comb begin
    score_d = score_q;
    if (&wrap) score_d = score_two;
    else if (|wrap) score_d = score_one;
  end

  always_ff @(posedge iVGA_CLK) begin
    if (reset_game) begin
      state_q       <= IDLE;
      game_over_q   <= 1'b0;
      hit_flash_q   <= 1'b0;
      restart_req_q <= 1'b0;
      score_q       <= 16'h0000;
      // Sampling the live button keeps a press held through reset from counting
      btn_q         <= btn_start;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]    <= 4'd0;
        prev_v_q[i] <= 9'd0;
      end
`ifdef LIVES_EN
      lives_q       <= LIVES_N;
`endif
    end else begin
      btn_q         <= btn_start;
      restart_req_q <= 1'b0;
      if (btn_rise && state_q != PLAYING) begin
        restart_req_q <= 1'b1;
        state_q       <= PLAYING;
        game_over_q   <= 1'b0;
        hit_flash_q   <= 1'b0;
        score_q       <= 16'h0000;
        for (int i = 0; i < 2; i++) cnt_q[i] <= 4'd0;
`ifdef LIVES_EN
        lives_q       <= LIVES_N;
`endif
      end else if (frame_tick && !restart_req_q) begin
        hit_flash_q <= 1'b0;
        for (int i = 0; i < 2; i++) prev_v_q[i] <= obs_v[i];
        if (state_q == PLAYING) begin
          for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
          if (hit) begin
            hit_flash_q <= 1'b1;
`ifdef LIVES_EN
            for (int i = 0; i < 2; i++) cnt_q[i] <= 4'd0;
            lives_q <= lives_q - 3'd1;
            if (lives_q == 3'd1) begin
              state_q     <= GAME_OVER;
              game_over_q <= 1'b1;
            end
`else
            state_q     <= GAME_OVER;
            game_over_q <= 1'b1;
`endif
          end else begin
            score_q <= score_d;
          end
        end
      end
    end
  end

  assign game_over   = game_over_q;
  assign hit_flash   = hit_flash_q;
  assign restart_req = restart_req_q;
  assign score_bcd   = score_q;

endmodule

// File: tb/tb_collision_monitor.sv
// Scoreboard bench for collision_monitor: stimulus pushes expected output events, a negedge
// monitor pops and compares on every restart pulse, game_over/lives/score change or flash rise.
module tb_collision_monitor;

  localparam int EV_RESTART = 0, EV_GO = 1, EV_LIVES = 2, EV_FLASH = 3, EV_SCORE = 4;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_game, frame_tick, btn_start;
  logic [9:0]  car_h_pos, obs1_h_pos, obs2_h_pos;
  logic [8:0]  car_v_pos, obs1_v_pos, obs2_v_pos;
  logic        game_over, hit_flash, restart_req;
  logic [15:0] score_bcd;
`ifdef LIVES_EN
  logic [2:0]  lives;
  logic [2:0]  lv_p = 3'd3;
`endif

  ev_t  exp_q[$];
  int   compared = 0, mismatched = 0;
  int   sc_m = 0;
  logic [8:0] p1 = 9'd0, p2 = 9'd0;
  logic playing_m = 1'b0, ph = 1'b0, quiet = 1'b0, mon_en = 1'b0;
  logic go_p = 1'b0, hf_p = 1'b0;
  logic [15:0] sc_p = 16'h0000;

  always #5 clk = ~clk;

  collision_monitor dut (
    .iVGA_CLK(clk), .reset_game(reset_game), .frame_tick(frame_tick), .btn_start(btn_start),
    .car_h_pos(car_h_pos), .car_v_pos(car_v_pos),
    .obs1_h_pos(obs1_h_pos), .obs1_v_pos(obs1_v_pos),
    .obs2_h_pos(obs2_h_pos), .obs2_v_pos(obs2_v_pos),
    .game_over(game_over), .hit_flash(hit_flash), .restart_req(restart_req),
`ifdef LIVES_EN
    .lives(lives),
`endif
    .score_bcd(score_bcd)
  );

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic push(input int k, input logic [15:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else $display("check %s ok (%h)", name, act);
  endtask

  task automatic mon_cmp(input int kind, input logic [15:0] act);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_event: kind %0d got %h expected no event", kind, act);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== act) begin
        mismatched++;
        $display("FAIL event: kind %0d got %h expected kind %0d value %h", kind, act, e.kind, e.val);
      end else if (!quiet) $display("event kind %0d value %h", kind, act);
    end
  endtask

  // Fixed in-cycle order: restart, game_over, lives, flash, score
  always @(negedge clk) begin
    if (mon_en) begin
      if (restart_req) mon_cmp(EV_RESTART, 16'h0000);
      if (game_over != go_p) mon_cmp(EV_GO, {15'd0, game_over});
`ifdef LIVES_EN
      if (lives != lv_p) mon_cmp(EV_LIVES, {13'd0, lives});
      lv_p = lives;
`endif
      if (hit_flash && !hf_p) mon_cmp(EV_FLASH, 16'h0001);
      if (score_bcd != sc_p) mon_cmp(EV_SCORE, score_bcd);
      go_p = game_over;
      hf_p = hit_flash;
      sc_p = score_bcd;
    end
  end

  // Model: scores wraps when playing and this tick is not a hit
  task automatic tick(input logic [8:0] v1, input logic [8:0] v2, input logic hit);
    int w, ns;
    w = ((v1 < p1) ? 1 : 0) + ((v2 < p2) ? 1 : 0);
    if (playing_m && !hit) begin
      ns = sc_m + w;
      if (ns > 9999) ns = 9999;
      if (ns != sc_m) push(EV_SCORE, to_bcd(ns));
      sc_m = ns;
    end
    p1 = v1;
    p2 = v2;
    obs1_v_pos = v1;
    obs2_v_pos = v2;
    repeat (2) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    if (!quiet) $display("tick v1=%0d v2=%0d hit=%0b model=%0d", v1, v2, hit, sc_m);
  endtask

  task automatic step();
    tick(ph ? 9'd0 : 9'd524, ph ? 9'd524 : 9'd0, 1'b0);
    ph = !ph;
  endtask

  task automatic press();
    btn_start = 1'b1;
    repeat (3) @(negedge clk);
    btn_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic hit_tick();
    tick(9'd380, 9'd0, 1'b1);
  endtask

  initial begin
    reset_game = 1'b1; frame_tick = 1'b0; btn_start = 1'b1;
    car_h_pos = 10'd300; car_v_pos = 9'd400;
    obs1_h_pos = 10'd600; obs1_v_pos = 9'd0;
    obs2_h_pos = 10'd700; obs2_v_pos = 9'd0;
    repeat (3) @(negedge clk);
    check("rst_game_over", {15'd0, game_over}, 16'h0000);
    check("rst_hit_flash", {15'd0, hit_flash}, 16'h0000);
    check("rst_restart", {15'd0, restart_req}, 16'h0000);
    check("rst_score", score_bcd, 16'h0000);
`ifdef LIVES_EN
    check("rst_lives", {13'd0, lives}, 16'h0003);
`endif
    reset_game = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);       // button held through reset: no restart expected
    btn_start = 1'b0;
    @(negedge clk);

    push(EV_RESTART, 16'h0000);
    press();
    playing_m = 1'b1;
    check("restart_done", {15'd0, restart_req}, 16'h0000);
    check("playing_no_go", {15'd0, game_over}, 16'h0000);

    tick(9'd524, 9'd524, 1'b0);
    tick(9'd0, 9'd0, 1'b0);
    check("double_wrap", score_bcd, 16'h0002);
    while (sc_m < 99) step();
    check("score_0099", score_bcd, 16'h0099);
    while (sc_m < 100) step();
    check("score_0100", score_bcd, 16'h0100);

    obs1_h_pos = 10'd280;
    tick(9'd380, 9'd524, 1'b0);
    check("one_frame_no_hit", {15'd0, game_over}, 16'h0000);
    obs1_h_pos = 10'd0;
    tick(9'd380, 9'd524, 1'b0);
    check("moved_away", {15'd0, game_over}, 16'h0000);
    obs1_h_pos = 10'd280;
    tick(9'd380, 9'd524, 1'b0);
    check("count_restarted", {15'd0, game_over}, 16'h0000);
`ifdef LIVES_EN
    push(EV_LIVES, 16'h0002); push(EV_FLASH, 16'h0001);
    hit_tick();
    check("lives_2", {13'd0, lives}, 16'h0002);
    check("lives_2_go", {15'd0, game_over}, 16'h0000);
    tick(9'd380, 9'd524, 1'b0);
    push(EV_LIVES, 16'h0001); push(EV_FLASH, 16'h0001);
    hit_tick();
    check("lives_1", {13'd0, lives}, 16'h0001);
    check("lives_1_go", {15'd0, game_over}, 16'h0000);
    tick(9'd380, 9'd524, 1'b0);
    push(EV_GO, 16'h0001); push(EV_LIVES, 16'h0000); push(EV_FLASH, 16'h0001);
    hit_tick();
    check("lives_0", {13'd0, lives}, 16'h0000);
`else
    push(EV_GO, 16'h0001); push(EV_FLASH, 16'h0001);
    hit_tick();
`endif
    check("hit_game_over", {15'd0, game_over}, 16'h0001);
    check("hit_flash_on", {15'd0, hit_flash}, 16'h0001);
    check("no_score_on_hit", score_bcd, to_bcd(sc_m));
    playing_m = 1'b0;
    tick(9'd380, 9'd524, 1'b0);
    check("hit_flash_off", {15'd0, hit_flash}, 16'h0000);
    obs1_h_pos = 10'd600;
    tick(9'd524, 9'd524, 1'b0);

    // Restart from GAME_OVER with a wrapping frame_tick in the restart_req cycle
    obs1_v_pos = 9'd0; obs2_v_pos = 9'd0;
    repeat (2) @(negedge clk);
    push(EV_RESTART, 16'h0000); push(EV_GO, 16'h0000);
`ifdef LIVES_EN
    push(EV_LIVES, 16'h0003);
`endif
    push(EV_SCORE, 16'h0000);
    sc_m = 0;
    btn_start = 1'b1;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    btn_start = 1'b0;
    playing_m = 1'b1;
    check("restart_wins_tick", score_bcd, 16'h0000);
    check("restart_go_clear", {15'd0, game_over}, 16'h0000);
    tick(9'd524, 9'd524, 1'b0);

    quiet = 1'b1;
    while (sc_m < 9998) step();
    quiet = 1'b0;
    check("score_9998", score_bcd, 16'h9998);
    tick(9'd524, 9'd524, 1'b0);
    tick(9'd0, 9'd0, 1'b0);
    check("saturate_9999", score_bcd, 16'h9999);
    tick(9'd524, 9'd524, 1'b0);
    tick(9'd0, 9'd0, 1'b0);
    check("stay_9999", score_bcd, 16'h9999);

    push(EV_SCORE, 16'h0000);
    reset_game = 1'b1;
    repeat (2) @(negedge clk);
    reset_game = 1'b0;
    sc_m = 0; p1 = 9'd0; p2 = 9'd0; playing_m = 1'b0;
    @(negedge clk);
    check("midrst_score", score_bcd, 16'h0000);
    check("midrst_restart", {15'd0, restart_req}, 16'h0000);
    tick(9'd524, 9'd524, 1'b0);
    tick(9'd0, 9'd0, 1'b0);
    check("idle_no_score", score_bcd, 16'h0000);

    repeat (5) @(negedge clk);
    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missing_event: got none expected kind %0d value %h", e.kind, e.val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
